// File: rtl/hex_display_bank.sv
// Multi-digit seven-segment hex driver: captures packed nibbles on load, decodes to
// active-low glyphs with per-digit blinking, leading-zero blanking and a scanned output.
module hex_display_bank #(
    parameter int DIGITS    = 4,
    parameter int BLINK_DIV = 25000000,
    parameter int SCAN_DIV  = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     blink_en,
    input  logic                  lzb,
    input  logic                  scan_mode,
    output logic [7*DIGITS-1:0]   hex_seg,
    output logic [6:0]            scan_seg,
    output logic [DIGITS-1:0]     scan_sel,
    output logic                  blink_phase
);

    localparam int BW = $clog2(BLINK_DIV);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [6:0] BLANK = 7'h7F;

    function automatic logic [6:0] f_glyph(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h18;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    logic [4*DIGITS-1:0] r_disp;
    logic [BW-1:0]       r_blink_cnt;
    logic                r_blink_phase;
    logic [PW-1:0]       r_pre;
    logic [IW-1:0]       r_idx;
    logic [7*DIGITS-1:0] r_hex_seg;
    logic [6:0]          r_scan_seg;
    logic [DIGITS-1:0]   r_scan_sel;

    logic                w_blink_wrap;
    logic                w_pre_wrap;
    logic [IW-1:0]       w_idx_next;
    logic [DIGITS:0]     w_zero_from;
    logic [DIGITS-1:0]   w_blank;
    logic [7*DIGITS-1:0] w_seg_next;
    logic [6:0]          w_scan_seg_next;
    logic [DIGITS-1:0]   w_scan_sel_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_disp <= '0;
        end else if (load) begin
            r_disp <= value;
        end
    end

    assign w_blink_wrap = (r_blink_cnt == BW'(BLINK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_blink_wrap) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
        end else begin
            r_blink_cnt   <= r_blink_cnt + 1'b1;
        end
    end

    // w_zero_from[i]: nibble i and every nibble above it are zero.
    always_comb begin
        w_zero_from         = '0;
        w_zero_from[DIGITS] = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_zero_from[i] = w_zero_from[i+1] && (r_disp[4*i +: 4] == 4'h0);
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        if (g == 0) begin : g_lsd
            assign w_blank[g] = blink_en[g] && r_blink_phase;
        end else begin : g_upper
            assign w_blank[g] = (lzb && w_zero_from[g]) || (blink_en[g] && r_blink_phase);
        end
        assign w_seg_next[7*g +: 7] = w_blank[g] ? BLANK : f_glyph(r_disp[4*g +: 4]);
    end

    assign w_pre_wrap = (r_pre == PW'(SCAN_DIV - 1));
    assign w_idx_next = (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pre <= '0;
            r_idx <= '0;
        end else if (!scan_mode) begin
            r_pre <= '0;
            r_idx <= '0;
        end else if (w_pre_wrap) begin
            r_pre <= '0;
            r_idx <= w_idx_next;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    // Select and glyph come from the same index so they can never disagree.
    always_comb begin
        w_scan_sel_next = '1;
        w_scan_seg_next = BLANK;
        if (scan_mode) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (r_idx == IW'(i)) begin
                    w_scan_sel_next[i] = 1'b0;
                    w_scan_seg_next    = w_seg_next[7*i +: 7];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hex_seg  <= {DIGITS{BLANK}};
            r_scan_seg <= BLANK;
            r_scan_sel <= '1;
        end else begin
            r_hex_seg  <= w_seg_next;
            r_scan_seg <= w_scan_seg_next;
            r_scan_sel <= w_scan_sel_next;
        end
    end

    assign hex_seg     = r_hex_seg;
    assign scan_seg    = r_scan_seg;
    assign scan_sel    = r_scan_sel;
    assign blink_phase = r_blink_phase;

endmodule

// File: tb/tb_hex_display_bank.sv
// Bench for hex_display_bank: behavioural model pushes expected outputs per clock edge,
// a negedge monitor pops and compares; directed checks cover reset and glyph constants.
module tb_hex_display_bank;

    localparam int DIGITS    = 4;
    localparam int BLINK_DIV = 8;
    localparam int SCAN_DIV  = 3;
    localparam int W         = 28 + 7 + 4 + 1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  blink_en = '0;
    logic        lzb = 1'b0;
    logic        scan_mode = 1'b0;
    logic [27:0] hex_seg;
    logic [6:0]  scan_seg;
    logic [3:0]  scan_sel;
    logic        blink_phase;

    hex_display_bank #(
        .DIGITS    (DIGITS),
        .BLINK_DIV (BLINK_DIV),
        .SCAN_DIV  (SCAN_DIV)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .value       (value),
        .blink_en    (blink_en),
        .lzb         (lzb),
        .scan_mode   (scan_mode),
        .hex_seg     (hex_seg),
        .scan_seg    (scan_seg),
        .scan_sel    (scan_sel),
        .blink_phase (blink_phase)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    logic [W-1:0] exp_q[$];

    logic [6:0] glyph_tab [16];
    initial glyph_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                          7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase from edge count, scan index from run length of scan_mode.
    logic [15:0] m_disp = '0;
    int          m_edges = 0;
    int          m_scan_run = 0;

    function automatic logic [27:0] model_hex(input logic [15:0] disp, input bit phase,
                                              input logic lz, input logic [3:0] ben);
        logic [27:0] r;
        bit blank;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            blank = (lz && i > 0 && ((disp >> (4 * i)) == 16'h0)) || (ben[i] && phase);
            r[7*i +: 7] = blank ? 7'h7F : glyph_tab[disp[4*i +: 4]];
        end
        return r;
    endfunction

    always @(posedge clk or posedge reset) begin
        logic [27:0] hexv;
        logic [6:0]  segv;
        logic [3:0]  selv;
        int          idx;
        bit          ph;
        if (reset) begin
            m_disp     = '0;
            m_edges    = 0;
            m_scan_run = 0;
            exp_q.delete();
        end else begin
            ph   = ((m_edges / BLINK_DIV) % 2) == 1;
            hexv = model_hex(m_disp, ph, lzb, blink_en);
            selv = 4'hF;
            segv = 7'h7F;
            if (scan_mode) begin
                idx       = (m_scan_run / SCAN_DIV) % DIGITS;
                selv[idx] = 1'b0;
                segv      = hexv[7*idx +: 7];
                m_scan_run++;
            end else begin
                m_scan_run = 0;
            end
            if (load) m_disp = value;
            m_edges++;
            ph = ((m_edges / BLINK_DIV) % 2) == 1;
            exp_q.push_back({hexv, segv, selv, ph});
        end
    end

    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!reset && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("hex_seg",     32'(hex_seg),     32'(e[39:12]));
            check("scan_seg",    32'(scan_seg),    32'(e[11:5]));
            check("scan_sel",    32'(scan_sel),    32'(e[4:1]));
            check("blink_phase", 32'(blink_phase), 32'(e[0]));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] v);
        load  = 1'b1;
        value = v;
        @(negedge clk);
        load  = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_hex"},   32'(hex_seg),     32'h0FFFFFFF);
        check({tag, "_seg"},   32'(scan_seg),    32'h7F);
        check({tag, "_sel"},   32'(scan_sel),    32'hF);
        check({tag, "_phase"}, 32'(blink_phase), 32'h0);
    endtask

    logic [15:0] sweep [4];

    initial begin
        sweep = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
        #2 reset = 1'b1;
        #1 check_reset_outputs("rst_init");
        cyc(2);
        reset = 1'b0;
        cyc(2);

        do_load(16'h1234);
        cyc(1);
        check("load_1234", 32'(hex_seg), 32'({7'h79, 7'h24, 7'h30, 7'h19}));

        foreach (sweep[k]) begin
            do_load(sweep[k]);
            cyc(2);
        end
        check("sweep_CDEF", 32'(hex_seg), 32'({7'h46, 7'h21, 7'h06, 7'h0E}));
        do_load(16'h89AB);
        cyc(1);
        check("sweep_89AB", 32'(hex_seg), 32'({7'h00, 7'h18, 7'h08, 7'h03}));

        lzb = 1'b1;
        do_load(16'h0040);
        cyc(1);
        check("lzb_0040", 32'(hex_seg), 32'({7'h7F, 7'h7F, 7'h19, 7'h40}));
        do_load(16'h0000);
        cyc(1);
        check("lzb_0000", 32'(hex_seg), 32'({7'h7F, 7'h7F, 7'h7F, 7'h40}));
        lzb = 1'b0;

        do_load(16'h1234);
        blink_en = 4'b0010;
        cyc(40);
        blink_en = 4'b0000;

        scan_mode = 1'b1;
        cyc(30);
        scan_mode = 1'b0;
        cyc(1);
        check("scan_off_sel", 32'(scan_sel), 32'hF);
        check("scan_off_seg", 32'(scan_seg), 32'h7F);

        repeat (800) begin
            load     = ($urandom_range(0, 3) == 0);
            value    = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            blink_en = 4'($urandom_range(0, 15));
            lzb      = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) scan_mode = ~scan_mode;
            @(negedge clk);
        end
        load = 1'b0;

        scan_mode = 1'b1;
        blink_en  = 4'hF;
        do_load(16'h0A5C);
        cyc(17);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 check_reset_outputs("rst_mid");
        @(negedge clk);
        reset = 1'b0;
        cyc(1);
        check("post_rst_sel",   32'(scan_sel),    32'hE);
        check("post_rst_phase", 32'(blink_phase), 32'h0);
        cyc(30);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
